inv_factorial: RTL and testbench

- Inverse of the factorial unit: given a 32-bit value, it finds n such that n! == value, or flags that value is not a factorial.
- Uses the same go/done/error/CS handshake as the forward factorial unit. Used to check factorial products and to decode them back to n.
- Iterative design: one running product register and one counter; one multiply-and-compare per cycle.

---
 rtl/inv_factorial.sv | 114 +++++++++++
 tb/tb_inv_factorial.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/inv_factorial.sv
// Inverse factorial: finds n with n! == value (n <= NMAX), else flags error; optional INV_FACT_FLOOR_EN adds `exact` and floor decoding.
// Latency: done in the cycle after accept+(n+2) for a match, accept+1 for value 0; go is ignored outside IDLE (no queuing).
module inv_factorial #(
  parameter int NMAX = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [31:0] value,
  output logic [3:0]  n,
  output logic        done,
  output logic        error,
  output logic [1:0]  CS
`ifdef INV_FACT_FLOOR_EN
  ,
  output logic        exact
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] NMAX_I = 4'(NMAX);

  state_t      cs, ns;
  logic [31:0] acc;
  logic [31:0] value_r;
  logic [3:0]  i;
  logic        hit, over, last;

  assign hit  = (acc == value_r);
  assign over = (acc > value_r);
  assign last = (i == NMAX_I);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cs <= IDLE;
    else      cs <= ns;
  end

  always_comb begin
    ns = cs;
    case (cs)
      IDLE: if (go) ns = LOAD;
      LOAD: ns = (value_r == 32'd0) ? DONE : CALC;
      CALC: if (hit || over || last) ns = DONE;
      DONE: ns = IDLE;
      default: ns = IDLE;
    endcase
  end

  always_comb begin
    done = (cs == DONE);
    CS   = cs;
  end

  // acc holds i! while in CALC; no multiply is issued once i reaches NMAX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= 32'd1;
      i       <= 4'd0;
      value_r <= 32'd0;
      n       <= 4'd0;
      error   <= 1'b0;
`ifdef INV_FACT_FLOOR_EN
      exact   <= 1'b0;
`endif
    end else begin
      case (cs)
        IDLE: begin
          if (go) begin
            value_r <= value;
            n       <= 4'd0;
            error   <= 1'b0;
`ifdef INV_FACT_FLOOR_EN
            exact   <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (value_r == 32'd0) begin
            error <= 1'b1;
          end else begin
            acc <= 32'd1;
            i   <= 4'd0;
          end
        end
        CALC: begin
          if (hit) begin
            n <= i;
`ifdef INV_FACT_FLOOR_EN
            exact <= 1'b1;
`endif
          end else if (over || last) begin
`ifdef INV_FACT_FLOOR_EN
            // over can never fire at i==0 since acc starts at 1 and value_r >= 1
            n <= over ? (i - 4'd1) : NMAX_I;
`else
            error <= 1'b1;
`endif
          end else begin
            acc <= acc * {28'd0, i + 4'd1};
            i   <= i + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_factorial.sv
// Scoreboard bench for inv_factorial: directed decodes, latency, hold, go-held and mid-run reset cases.
module tb_inv_factorial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [31:0] value = 32'd0;
  logic [3:0]  n;
  logic        done;
  logic        error;
  logic [1:0]  CS;
`ifdef INV_FACT_FLOOR_EN
  logic        exact;
  localparam bit FLOOR = 1'b1;
`else
  localparam bit FLOOR = 1'b0;
`endif

  inv_factorial #(.NMAX(12)) dut (
    .clk(clk),
    .rst(rst),
    .go(go),
    .value(value),
    .n(n),
    .done(done),
    .error(error),
    .CS(CS)
`ifdef INV_FACT_FLOOR_EN
    ,
    .exact(exact)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [3:0] n;
    logic       err;
    logic       ex;
    int         lat;
    int         e0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done=1 n=%0d error=%0d, expected no pending decode", n, error);
        end else begin
          mon_e = sb.pop_front();
          check("n", 32'(n), 32'(mon_e.n));
          check("error", 32'(error), 32'(mon_e.err));
`ifdef INV_FACT_FLOOR_EN
          check("exact", 32'(exact), 32'(mon_e.ex));
`endif
          check("latency", 32'(cyc - mon_e.e0), 32'(mon_e.lat));
        end
      end
    end
  end

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL timeout: got %0d pending decodes, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [31:0] v, input logic [3:0] en, input logic eerr,
                     input logic eex, input int lat, input bit trace);
    exp_t e;
    logic [1:0] exp_cs [9];
    exp_cs = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
    @(negedge clk);
    go = 1'b1;
    value = v;
    e.n = en; e.err = eerr; e.ex = eex; e.lat = lat; e.e0 = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    go = 1'b0;
    check("accept_cs", 32'(CS), 32'd1);
    check("accept_n", 32'(n), 32'd0);
    check("accept_error", 32'(error), 32'd0);
    if (trace) begin
      for (int k = 0; k < 9; k++) begin
        @(negedge clk);
        check("cs_trace", 32'(CS), 32'(exp_cs[k]));
      end
    end
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b0;
    #1;
    check("reset_cs", 32'(CS), 32'd0);
    check("reset_n", 32'(n), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_done", 32'(done), 32'd0);
`ifdef INV_FACT_FLOOR_EN
    check("reset_exact", 32'(exact), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    run(32'd120, 4'd5, 1'b0, 1'b1, 7, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_n", 32'(n), 32'd5);
    check("hold_error", 32'(error), 32'd0);

    run(32'd1, 4'd0, 1'b0, 1'b1, 2, 1'b0);
    run(32'd479001600, 4'd12, 1'b0, 1'b1, 14, 1'b0);
    run(32'd121, FLOOR ? 4'd5 : 4'd0, !FLOOR, 1'b0, 8, 1'b0);
    run(32'd0, 4'd0, 1'b1, 1'b0, 1, 1'b0);
    run(32'hFFFF_FFFF, FLOOR ? 4'd12 : 4'd0, !FLOOR, 1'b0, 14, 1'b0);

    // go held through a whole run: one decode of 24, then a fresh run of 6 on the next IDLE cycle
    begin
      exp_t e;
      int e0;
      @(negedge clk);
      go = 1'b1;
      value = 32'd24;
      e.n = 4'd4; e.err = 1'b0; e.ex = 1'b1; e.lat = 6; e.e0 = cyc + 1;
      sb.push_back(e);
      e.n = 4'd3; e.err = 1'b0; e.ex = 1'b1; e.lat = 5; e.e0 = cyc + 9;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e0 = cyc;
      repeat (3) @(posedge clk);
      #1;
      value = 32'd6;
      while (cyc < e0 + 8) begin
        @(posedge clk);
        #1;
      end
      go = 1'b0;
      drain();
    end

    // asynchronous reset in the middle of CALC (i==3 for 720)
    @(negedge clk);
    go = 1'b1;
    value = 32'd720;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_cs", 32'(CS), 32'd0);
    check("midrst_n", 32'(n), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run(32'd6, 4'd3, 1'b0, 1'b1, 5, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
